mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port memory controller behind the 4-way request arbiter.
- Takes the arbiter's level-request / single-cycle-ready handshake and sequences one access at a time to a synchronous SRAM with a fixed read latency.
- Returns read data on the shared data bus.
- Flags out-of-range addresses without touching the SRAM.

Parameters:
- DATA_W, 64: data width, arbiter side and SRAM side.
- ADDR_W, 64: arbiter-side byte address width.
- MEM_AW, 10: SRAM word-address width (2^MEM_AW words of DATA_W bits).
- RD_LAT, 2: SRAM read latency in cycles, from the mem_en cycle to a valid mem_rdata. Legal range 1..7.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_m  in  ADDR_W  byte address from the arbiter; bits [2:0] ignored.
- dout_m  in  DATA_W  write data from the arbiter.
- req_m  in  1  request level, held high by the arbiter until rdy_m.
- wr_m  in  1  1 = write, 0 = read; valid while req_m is high.
- din_m  out  DATA_W  read data to the arbiter (registered).
- rdy_m  out  1  single-cycle completion pulse.
- err_m  out  1  pulses with rdy_m when the address is out of range.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable; qualified by mem_en.
- mem_addr  out  MEM_AW  SRAM word address = addr_m[MEM_AW+2:3].
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data.

Behaviour:
- Reset:
  - state = IDLE.
  - rdy_m, err_m, mem_en, mem_we = 0.
  - din_m, mem_addr, mem_wdata = 0.
  - Latency counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req_m = 1, latch addr_m, dout_m and wr_m.
  - In-range address: go to ISSUE.
  - Address bits [ADDR_W-1:MEM_AW+3] nonzero: go to RESP with error flag set; no SRAM access.
- ISSUE (one cycle):
  - mem_en = 1, mem_we = latched wr, mem_addr and mem_wdata from the latches.
  - Write: go to RESP.
  - Read: load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, capture mem_rdata into din_m and go to RESP.
- RESP (one cycle):
  - rdy_m = 1; err_m = error flag.
  - Next state: IDLE.
- Latency, counted from the IDLE cycle where req_m is first sampled high:
  - Write: rdy_m high in cycle +2.
  - Read: rdy_m high in cycle RD_LAT+2.
  - Out-of-range: rdy_m high in cycle +1.
- mem_en and mem_we are high only in ISSUE.
- din_m:
  - Changes only on a read capture.
  - Holds its value otherwise, including across writes and errors.
  - On an out-of-range read, din_m is set to all-zeros in the RESP cycle.
- Back-to-back requests:
  - The arbiter drops req_m for at least one cycle after rdy_m.
  - If req_m is high in IDLE immediately after RESP, it is accepted as a new request; no extra idle cycle is enforced.
- req_m low while in ISSUE, WAIT or RESP (protocol violation):
  - The SRAM access already issued still completes.
  - rdy_m and err_m are suppressed.
  - Read data is not captured.
  - Return to IDLE at the point where RESP would have occurred.
- Changes to wr_m, addr_m or dout_m after acceptance are ignored.
- Reset mid-operation:
  - All state returns to reset values on the next edge.
  - No rdy_m is issued.
  - An ISSUE-cycle write in the same cycle as reset is still presented to the SRAM (outputs are registered from the prior cycle).

Optional Feature:
- Macro: MEM_CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_cnt (32-bit), wr_cnt (32-bit) and err_cnt (16-bit).
  - Each increments once per completed read, write or error, i.e. per rdy_m pulse of that type.
  - Counters saturate at all-ones; they do not wrap.
  - Cleared by reset.
  - Suppressed (aborted) operations are not counted.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Write then read: write addr 0x18 data 0xDEADBEEF_CAFEF00D, then read 0x18 with RD_LAT=2.
   Required: write rdy_m at +2 with mem_addr=3 and mem_we=1; read rdy_m at +4 with din_m=0xDEADBEEF_CAFEF00D; err_m=0 throughout.
2. Out-of-range read: addr 0x2000 (MEM_AW=10).
   Required: rdy_m and err_m at +1, din_m=0, mem_en never asserted.
3. RD_LAT sweep: RD_LAT=1 and RD_LAT=7, read of preloaded word 0x5A.
   Required: rdy_m exactly at +3 and +9 respectively, with correct data.
4. Abort: read issued, req_m dropped during WAIT.
   Required: no rdy_m, din_m unchanged, state IDLE at the expected RESP cycle, the next request served normally.
5. Back-to-back: req_m re-asserted in the cycle after rdy_m.
   Required: accepted immediately; second write rdy_m 3 cycles after the first.
6. Reset mid-read: reset asserted during WAIT.
   Required: outputs at reset values next cycle, no rdy_m pulse; with MEM_CTRL_PERF_CNT_EN defined, all counters = 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences one arbiter request at a time onto a synchronous single-port SRAM.
// Optional: define MEM_CTRL_PERF_CNT_EN to add saturating read/write/error counters.
module mem_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_m,
    input  logic [DATA_W-1:0] dout_m,
    input  logic              req_m,
    input  logic              wr_m,
    output logic [DATA_W-1:0] din_m,
    output logic              rdy_m,
    output logic              err_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rdy_q, rdy_d;
    logic                err_o_q, err_o_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                drop;
    logic                oor;
    logic                unused_addr_lsb;

    assign oor             = |addr_m[ADDR_W-1:MEM_AW+3];
    assign unused_addr_lsb = ^addr_m[2:0];

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        err_d       = err_q;
        abort_d     = abort_q;
        cnt_d       = cnt_q;
        din_d       = din_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        drop        = 1'b0;
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (req_m) begin
                    wr_d = wr_m;
                    if (oor) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                        if (!wr_m) din_d = '0;
                    end else begin
                        err_d       = 1'b0;
                        mem_addr_d  = addr_m[MEM_AW+2:3];
                        mem_wdata_d = dout_m;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A dropped request still lets the issued access finish, but never responds.
                drop    = abort_q | ~req_m;
                abort_d = drop;
                if (wr_q) begin
                    state_d = drop ? IDLE : RESP;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                drop    = abort_q | ~req_m;
                abort_d = drop;
                if (cnt_q == 3'd0) begin
                    if (!drop) din_d = mem_rdata;
                    state_d = drop ? IDLE : RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdy_d    = (state_d == RESP);
        err_o_d  = (state_d == RESP) & err_d;
        mem_en_d = (state_d == ISSUE);
        mem_we_d = (state_d == ISSUE) & wr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            cnt_q       <= 3'd0;
            din_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdy_q       <= 1'b0;
            err_o_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdy_q       <= rdy_d;
            err_o_q     <= err_o_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    // The response is masked by req_m so a request withdrawn during RESP is not acknowledged.
    assign rdy_m     = rdy_q & req_m;
    assign err_m     = err_o_q & req_m;
    assign din_m     = din_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_CTRL_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (rdy_m) begin
            if (err_o_q) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (wr_q) begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign wr_cnt  = wr_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: three instances (RD_LAT 2, 1, 7) share one request stream.
module tb_mem_ctrl;
    localparam int NI = 3;
    localparam int M_NORM = 0, M_ABORT = 1, M_RESET = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] addr_m, dout_m;
    logic        wr_m;
    logic        req_w    [NI];
    logic [63:0] din_w    [NI];
    logic        rdy_w    [NI];
    logic        err_w    [NI];
    logic        mem_en_w [NI];
    logic        mem_we_w [NI];
    logic [9:0]  maddr_w  [NI];
    logic [63:0] mwdata_w [NI];
    logic [63:0] mrdata_w [NI];
`ifdef MEM_CTRL_PERF_CNT_EN
    logic [31:0] rd_cnt_w [NI];
    logic [31:0] wr_cnt_w [NI];
    logic [15:0] err_cnt_w[NI];
`endif

    typedef struct { int c0; int lat; logic err; logic [63:0] din; } rsp_t;
    typedef struct { int cyc; logic we; logic [9:0] addr; logic [63:0] wdata; } acc_t;
    rsp_t rsp_q [NI][$];
    acc_t acc_q [NI][$];

    logic [63:0] ref_mem [1024];
    logic [63:0] ref_din [NI];
    int ref_rd, ref_wr, ref_err;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_word(input int k);
        if (k == 32'h5A) return 64'h5A;
        return {32'(k), 32'(k)} ^ 64'hA5A5_0F0F_3C3C_9696;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 7;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        logic [63:0] mem  [1024];
        logic [63:0] pipe [L];
        mem_ctrl #(.DATA_W(64), .ADDR_W(64), .MEM_AW(10), .RD_LAT(L)) u_dut (
            .clk(clk), .reset(reset), .addr_m(addr_m), .dout_m(dout_m),
            .req_m(req_w[g]), .wr_m(wr_m), .din_m(din_w[g]), .rdy_m(rdy_w[g]),
            .err_m(err_w[g]), .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]),
            .mem_addr(maddr_w[g]), .mem_wdata(mwdata_w[g]), .mem_rdata(mrdata_w[g])
`ifdef MEM_CTRL_PERF_CNT_EN
            , .rd_cnt(rd_cnt_w[g]), .wr_cnt(wr_cnt_w[g]), .err_cnt(err_cnt_w[g])
`endif
        );
        initial for (int k = 0; k < 1024; k++) mem[k] = init_word(k);
        // SRAM model: data valid L cycles after the mem_en cycle, garbage otherwise
        always @(posedge clk) begin
            if (mem_en_w[g] && mem_we_w[g]) mem[maddr_w[g]] <= mwdata_w[g];
            pipe[0] <= (mem_en_w[g] && !mem_we_w[g]) ? mem[maddr_w[g]] : 64'hBAD0_BAD0_BAD0_BAD0;
            for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
        end
        assign mrdata_w[g] = pipe[L-1];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input int act, input int exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever a DUT presents a response or an SRAM access
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                rsp_t e;
                acc_t a;
                if (rdy_w[i]) begin
                    if (rsp_q[i].size() == 0) fail_now($sformatf("unexpected_rdy_%0d", i), 1, 0);
                    else begin
                        e = rsp_q[i].pop_front();
                        chk($sformatf("rdy_latency_%0d", i), 64'(cyc - e.c0), 64'(e.lat));
                        chk($sformatf("err_%0d", i), 64'(err_w[i]), 64'(e.err));
                        chk($sformatf("din_%0d", i), din_w[i], e.din);
                    end
                end
                if (err_w[i] && !rdy_w[i]) fail_now($sformatf("err_without_rdy_%0d", i), 1, 0);
                if (mem_we_w[i] && !mem_en_w[i]) fail_now($sformatf("we_without_en_%0d", i), 1, 0);
                if (mem_en_w[i]) begin
                    if (acc_q[i].size() == 0) fail_now($sformatf("unexpected_mem_en_%0d", i), 1, 0);
                    else begin
                        a = acc_q[i].pop_front();
                        chk($sformatf("mem_cycle_%0d", i), 64'(cyc), 64'(a.cyc));
                        chk($sformatf("mem_we_%0d", i), 64'(mem_we_w[i]), 64'(a.we));
                        chk($sformatf("mem_addr_%0d", i), 64'(maddr_w[i]), 64'(a.addr));
                        if (a.we) chk($sformatf("mem_wdata_%0d", i), mwdata_w[i], a.wdata);
                    end
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_rdy_%0d", tag, i), 64'(rdy_w[i]), 64'd0);
            chk($sformatf("%s_err_%0d", tag, i), 64'(err_w[i]), 64'd0);
            chk($sformatf("%s_mem_en_%0d", tag, i), 64'(mem_en_w[i]), 64'd0);
            chk($sformatf("%s_mem_we_%0d", tag, i), 64'(mem_we_w[i]), 64'd0);
            chk($sformatf("%s_din_%0d", tag, i), din_w[i], 64'd0);
            chk($sformatf("%s_mem_addr_%0d", tag, i), 64'(maddr_w[i]), 64'd0);
            chk($sformatf("%s_mem_wdata_%0d", tag, i), mwdata_w[i], 64'd0);
`ifdef MEM_CTRL_PERF_CNT_EN
            chk($sformatf("%s_rd_cnt_%0d", tag, i), 64'(rd_cnt_w[i]), 64'd0);
            chk($sformatf("%s_wr_cnt_%0d", tag, i), 64'(wr_cnt_w[i]), 64'd0);
            chk($sformatf("%s_err_cnt_%0d", tag, i), 64'(err_cnt_w[i]), 64'd0);
`endif
        end
    endtask

    task automatic gap(input int n);
        repeat (n + 1) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Called at negedge+1; raises req on all instances and follows the transaction to its end.
    task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                       input int mode, input int dpt);
        int c0, k;
        logic oor;
        logic [9:0] w;
        bit busy;
        c0  = cyc;
        oor = (addr[63:13] != 51'd0);
        w   = addr[12:3];
        addr_m = addr;
        dout_m = data;
        wr_m   = wr;
        for (int i = 0; i < NI; i++) begin
            acc_t a;
            rsp_t r;
            req_w[i] = 1'b1;
            if (!oor) begin
                a.cyc = c0 + 1; a.we = wr; a.addr = w; a.wdata = data;
                acc_q[i].push_back(a);
            end
            if (mode == M_NORM) begin
                r.c0  = c0;
                r.err = oor;
                r.lat = oor ? 1 : (wr ? 2 : lat_of(i) + 2);
                if (!wr) ref_din[i] = oor ? 64'd0 : ref_mem[w];
                r.din = ref_din[i];
                rsp_q[i].push_back(r);
            end
        end
        if (!oor && wr) ref_mem[w] = data;
        if (mode == M_NORM) begin
            if (oor) ref_err++;
            else if (wr) ref_wr++;
            else ref_rd++;
        end
        busy = 1'b1;
        while (busy) begin
            @(negedge clk);
            #1;
            k = cyc - c0;
            addr_m = {$urandom, $urandom};
            dout_m = {$urandom, $urandom};
            wr_m   = 1'($urandom_range(0, 1));
            case (mode)
                M_NORM: begin
                    busy = 1'b0;
                    for (int i = 0; i < NI; i++) begin
                        if (req_w[i] && rdy_w[i]) req_w[i] = 1'b0;
                        if (req_w[i]) busy = 1'b1;
                    end
                end
                M_ABORT: begin
                    if (k == dpt) for (int i = 0; i < NI; i++) req_w[i] = 1'b0;
                    if (k >= 10) begin
                        for (int i = 0; i < NI; i++)
                            chk($sformatf("abort_din_held_%0d", i), din_w[i], ref_din[i]);
                        busy = 1'b0;
                    end
                end
                default: begin
                    if (k == 2) begin
                        reset = 1'b1;
                        for (int i = 0; i < NI; i++) req_w[i] = 1'b0;
                    end else if (k == 3) begin
                        chk_reset("midrst");
                        reset = 1'b0;
                        for (int i = 0; i < NI; i++) ref_din[i] = 64'd0;
                        ref_rd = 0; ref_wr = 0; ref_err = 0;
                        busy = 1'b0;
                    end
                end
            endcase
            if (busy && k > 25) begin
                fail_now("txn_timeout", k, 25);
                for (int i = 0; i < NI; i++) req_w[i] = 1'b0;
                busy = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        addr_m = '0; dout_m = '0; wr_m = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_w[i] = 1'b0;
            ref_din[i] = 64'd0;
        end
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
        ref_rd = 0; ref_wr = 0; ref_err = 0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        #1 reset = 1'b0;
        gap(0);

        txn(1'b1, 64'h18, 64'hDEADBEEF_CAFEF00D, M_NORM, 0);  gap(1);
        txn(1'b0, 64'h18, 64'h0, M_NORM, 0);                  gap(1);
        txn(1'b0, 64'h2000, 64'h0, M_NORM, 0);                gap(1);
        txn(1'b0, 64'h2D0, 64'h0, M_NORM, 0);                 gap(1);
        txn(1'b1, 64'h4000_0000_0000_0040, 64'h1234, M_NORM, 0); gap(1);
        txn(1'b0, 64'h2D8, 64'h0, M_ABORT, 2);                gap(0);
        txn(1'b0, 64'h18, 64'h0, M_NORM, 0);                  gap(1);
        txn(1'b0, 64'h2E0, 64'h0, M_ABORT, 1);                gap(1);
        txn(1'b1, 64'h20, 64'h1111_2222_3333_4444, M_NORM, 0); gap(0);
        txn(1'b1, 64'h28, 64'h5555_6666_7777_8888, M_NORM, 0); gap(0);
        txn(1'b0, 64'h20, 64'h0, M_NORM, 0);                  gap(1);
        txn(1'b0, 64'h28, 64'h0, M_RESET, 0);                 gap(1);
        txn(1'b0, 64'h28, 64'h0, M_NORM, 0);                  gap(1);

        for (int n = 0; n < 150; n++) begin
            int mode, r;
            logic wr;
            logic [63:0] a, d;
            r    = $urandom_range(0, 19);
            mode = (r == 0) ? M_ABORT : (r == 1) ? M_RESET : M_NORM;
            wr   = (mode == M_NORM) ? 1'($urandom_range(0, 1)) : 1'b0;
            d    = {$urandom, $urandom};
            a    = 64'd0;
            a[12:3] = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
            a[2:0]  = 3'($urandom_range(0, 7));
            if (mode == M_NORM && $urandom_range(0, 7) == 0) a[13 + $urandom_range(0, 50)] = 1'b1;
            txn(wr, a, d, mode, $urandom_range(1, 2));
            gap($urandom_range(0, 2));
        end

        gap(3);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rsp_left_%0d", i), 64'(rsp_q[i].size()), 64'd0);
            chk($sformatf("acc_left_%0d", i), 64'(acc_q[i].size()), 64'd0);
            chk($sformatf("final_din_%0d", i), din_w[i], ref_din[i]);
`ifdef MEM_CTRL_PERF_CNT_EN
            chk($sformatf("rd_cnt_%0d", i), 64'(rd_cnt_w[i]), 64'(ref_rd));
            chk($sformatf("wr_cnt_%0d", i), 64'(wr_cnt_w[i]), 64'(ref_wr));
            chk($sformatf("err_cnt_%0d", i), 64'(err_cnt_w[i]), 64'(ref_err));
`endif
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
